// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced N-to-2^N decoder.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package decoder_pkg;

  // Widest select code the onehot helper supports.
  localparam int MAX_N = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // One-hot expansion of a code; callers cast the result down to their width.
  function automatic logic [(1<<MAX_N)-1:0] onehot(input logic [MAX_N-1:0] code);
    onehot       = '0;
    onehot[code] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_nx2n_seq_dwell.sv
// Enable-gated modulo-DWELL counter with a terminal-count flag.
// Latency: tc is combinational from the current count and run.
// Backpressure: run low holds the count; clr forces it back to zero.
module dwell_counter #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tc
);

  localparam int W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [W-1:0] LAST = W'(DWELL - 1);

  logic [W-1:0] cnt;

  assign tc = run & (cnt == LAST);

  // Count enabled cycles, wrapping to zero on the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_nx2n_seq.sv
// N-to-2^N one-hot decoder with handshaked direct mode and autonomous sweep.
// Latency: one cycle from accepted request or sweep step to registered out.
// Backpressure: in_ready drops during a sweep and while en is low; en low freezes all state.
module decoder_nx2n_seq
  import decoder_pkg::*;
#(
  parameter int N          = 3,
  parameter int DWELL      = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [N-1:0]      in_sel,
  output logic              in_ready,
  input  logic              sweep_start,
  output logic [(1<<N)-1:0] out,
  output logic              out_valid,
  output logic [N-1:0]      cur_sel,
  output logic              sweep_done
);

  localparam int OW = 1 << N;
  localparam logic [N-1:0]  LAST_SEL = {N{1'b1}};
  localparam logic [OW-1:0] IDLE_PAT = (ACTIVE_LOW != 0) ? {OW{1'b1}} : {OW{1'b0}};

  // Line pattern for a selected code, honouring output polarity.
  function automatic logic [OW-1:0] pattern(input logic [N-1:0] s);
    logic [OW-1:0] oh;
    oh = OW'(onehot(MAX_N'(s)));
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  state_t        state_q, state_d;
  logic [N-1:0]  sel_q, sel_d;
  logic [OW-1:0] out_q, out_d;
  logic          vld_q, vld_d;
  logic          done_q, done_d;
  logic          cnt_run, cnt_clr, cnt_tc;

  assign cnt_run = en & (state_q == SWEEP);
  assign cnt_clr = en & (state_q == IDLE) & sweep_start;

  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .run (cnt_run),
    .clr (cnt_clr),
    .tc  (cnt_tc)
  );

  assign in_ready   = (state_q == IDLE) & en & ~rst;
  assign out        = out_q;
  assign out_valid  = vld_q;
  assign cur_sel    = sel_q;
  assign sweep_done = done_q;

  // Next-state and output selection; everything holds while en is low.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    out_d   = out_q;
    vld_d   = vld_q;
    done_d  = done_q;
    if (en) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          // A sweep request wins over a simultaneous direct request.
          if (sweep_start) begin
            state_d = SWEEP;
            sel_d   = '0;
            out_d   = pattern('0);
            vld_d   = 1'b1;
          end else if (in_valid) begin
            sel_d = in_sel;
            out_d = pattern(in_sel);
            vld_d = 1'b1;
          end
        end
        SWEEP: begin
          if (cnt_tc) begin
            if (sel_q == LAST_SEL) begin
              // Sweep finished: no wrap, drop back to idle lines.
              state_d = IDLE;
              sel_d   = '0;
              out_d   = IDLE_PAT;
              vld_d   = 1'b0;
              done_d  = 1'b1;
            end else begin
              sel_d = sel_q + 1'b1;
              out_d = pattern(sel_q + 1'b1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      out_q   <= IDLE_PAT;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Bench for decoder_nx2n_seq: three instances share stimulus
// (DWELL=1, DWELL=3, DWELL=1 with ACTIVE_LOW) and are compared each cycle
// against a sweep model based on elapsed enabled cycles.
module tb_decoder_nx2n_seq;

  logic       clk = 1'b0;
  logic       rst, en, in_valid, sweep_start;
  logic [2:0] in_sel;

  logic       rdy[3], vld[3], done[3];
  logic [7:0] o[3];
  logic [2:0] cs[3];

  int checks = 0;
  int errors = 0;

  // Reference model state per instance.
  bit m_busy[3];
  int m_t[3];
  int m_sel[3];
  bit m_vld[3];
  bit m_done[3];
  int dw[3] = '{1, 3, 1};
  bit al[3] = '{0, 0, 1};

  always #5 clk = ~clk;

  decoder_nx2n_seq #(.N(3), .DWELL(1), .ACTIVE_LOW(0)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_sel(in_sel),
    .in_ready(rdy[0]), .sweep_start(sweep_start), .out(o[0]),
    .out_valid(vld[0]), .cur_sel(cs[0]), .sweep_done(done[0]));

  decoder_nx2n_seq #(.N(3), .DWELL(3), .ACTIVE_LOW(0)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_sel(in_sel),
    .in_ready(rdy[1]), .sweep_start(sweep_start), .out(o[1]),
    .out_valid(vld[1]), .cur_sel(cs[1]), .sweep_done(done[1]));

  decoder_nx2n_seq #(.N(3), .DWELL(1), .ACTIVE_LOW(1)) u_dl (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_sel(in_sel),
    .in_ready(rdy[2]), .sweep_start(sweep_start), .out(o[2]),
    .out_valid(vld[2]), .cur_sel(cs[2]), .sweep_done(done[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_out(input int i);
    logic [7:0] v;
    v = m_vld[i] ? 8'(1 << m_sel[i]) : 8'h00;
    return al[i] ? ~v : v;
  endfunction

  // Apply one clock edge worth of inputs to the model.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_busy[i] = 0; m_t[i] = 0; m_sel[i] = 0; m_vld[i] = 0; m_done[i] = 0;
      end else if (en) begin
        m_done[i] = 0;
        if (!m_busy[i]) begin
          if (sweep_start) begin
            m_busy[i] = 1; m_t[i] = 0; m_sel[i] = 0; m_vld[i] = 1;
          end else if (in_valid) begin
            m_sel[i] = int'(in_sel); m_vld[i] = 1;
          end
        end else begin
          m_t[i]++;
          if (m_t[i] == 8 * dw[i]) begin
            m_busy[i] = 0; m_sel[i] = 0; m_vld[i] = 0; m_done[i] = 1;
          end else begin
            m_sel[i] = m_t[i] / dw[i];
          end
        end
      end
    end
  endtask

  // One cycle: drive inputs, check in_ready, take the edge, check outputs.
  task automatic cyc(input bit e, input bit v, input bit s, input logic [2:0] sel, input bit r);
    en = e; in_valid = v; sweep_start = s; in_sel = sel; rst = r;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'(!m_busy[i] && e && !r));
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out[%0d]", i), 32'(o[i]), 32'(exp_out(i)));
      chk($sformatf("out_valid[%0d]", i), 32'(vld[i]), 32'(m_vld[i]));
      chk($sformatf("cur_sel[%0d]", i), 32'(cs[i]), 32'(m_sel[i]));
      chk($sformatf("sweep_done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (m_busy[0] || m_busy[1] || m_busy[2]); k++)
      cyc(1, 0, 0, 3'd0, 0);
    chk("drain_idle", 32'(m_busy[0] || m_busy[1] || m_busy[2]), 32'd0);
    cyc(1, 0, 0, 3'd0, 0);
  endtask

  initial begin
    int first_done;
    int hold1, hold2;
    logic [7:0] e8;

    // Reset for two cycles.
    cyc(1, 0, 0, 3'd0, 1);
    cyc(1, 0, 0, 3'd0, 1);
    chk("rst_out", 32'(o[0]), 32'h00);
    chk("rst_out_al", 32'(o[2]), 32'hFF);
    chk("rst_valid", 32'(vld[0]), 32'd0);
    en = 1; rst = 0; in_valid = 0; sweep_start = 0;
    #1;
    chk("rdy_after_rst", 32'(rdy[0]), 32'd1);

    // Direct decode on consecutive cycles.
    cyc(1, 1, 0, 3'd5, 0);
    chk("direct5", 32'(o[0]), 32'h20);
    cyc(1, 1, 0, 3'd3, 0);
    chk("direct3", 32'(o[0]), 32'h08);
    cyc(1, 1, 0, 3'd6, 0);
    chk("direct6", 32'(o[0]), 32'h40);
    chk("direct6_al", 32'(o[2]), 32'hBF);
    chk("direct_valid", 32'(vld[0]), 32'd1);

    // Full DWELL=1 sweep.
    cyc(1, 0, 1, 3'd0, 0);
    chk("sweep_first", 32'(o[0]), 32'h01);
    for (int i = 1; i < 8; i++) begin
      cyc(1, 0, 0, 3'd0, 0);
      e8 = 8'h01 << i;
      chk("sweep_step", 32'(o[0]), 32'(e8));
      chk("sweep_rdy", 32'(rdy[0]), 32'd0);
    end
    cyc(1, 0, 0, 3'd0, 0);
    chk("sweep_end_out", 32'(o[0]), 32'h00);
    chk("sweep_end_valid", 32'(vld[0]), 32'd0);
    chk("sweep_end_done", 32'(done[0]), 32'd1);
    cyc(1, 0, 0, 3'd0, 0);
    chk("done_one_cycle", 32'(done[0]), 32'd0);
    drain();

    // DWELL=3 sweep with a 4-cycle pause while code 2 is shown.
    cyc(1, 0, 1, 3'd0, 0);
    first_done = -1; hold1 = 0; hold2 = 0;
    if (vld[1] && cs[1] == 3'd1) hold1++;
    for (int k = 1; k <= 32; k++) begin
      cyc(!(k >= 7 && k <= 10), 0, 0, 3'd0, 0);
      if (k == 8) chk("pause_sel", 32'(cs[1]), 32'd2);
      if (vld[1] && cs[1] == 3'd1) hold1++;
      if (vld[1] && cs[1] == 3'd2) hold2++;
      if (done[1] && first_done < 0) first_done = k;
    end
    chk("dwell3_hold1", 32'(hold1), 32'd3);
    chk("dwell3_hold2_paused", 32'(hold2), 32'd7);
    chk("dwell3_done_time", 32'(first_done), 32'd28);
    drain();

    // Sweep start beats a same-cycle request; held request waits for the end.
    cyc(1, 1, 1, 3'd7, 0);
    chk("simul_out", 32'(o[0]), 32'h01);
    chk("simul_sel", 32'(cs[0]), 32'd0);
    first_done = -1;
    for (int k = 1; k <= 20 && first_done < 0; k++) begin
      cyc(1, 1, 0, 3'd7, 0);
      if (done[0]) first_done = k;
    end
    chk("simul_done_time", 32'(first_done), 32'd8);
    cyc(1, 1, 0, 3'd7, 0);
    chk("held_req_out", 32'(o[0]), 32'h80);
    chk("held_req_sel", 32'(cs[0]), 32'd7);
    drain();

    // Reset in the middle of a sweep on the active-low instance.
    cyc(1, 0, 1, 3'd0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 3'd0, 0);
    chk("mid_sel", 32'(cs[2]), 32'd4);
    cyc(1, 0, 0, 3'd0, 1);
    chk("midrst_out", 32'(o[2]), 32'hFF);
    chk("midrst_valid", 32'(vld[2]), 32'd0);
    chk("midrst_done", 32'(done[2]), 32'd0);
    cyc(1, 1, 0, 3'd0, 0);
    chk("al_direct0", 32'(o[2]), 32'hFE);
    chk("al_no_done", 32'(done[2]), 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 9) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
          3'($urandom), $urandom_range(0, 49) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_nx2n_seq.md
Name: decoder_nx2n_seq

Overview:
- Parametrised N-to-2^N one-hot decoder with a registered output.
- Adds two modes on top of plain decoding:
  - a handshaked direct mode that decodes a host-supplied select;
  - an autonomous sweep mode that steps the one-hot output through every code, with a programmable dwell time per step.
- Drives chip-select or row-enable lines in the lab fabric, and acts as a self-test pattern source for downstream decode logic.

Parameters:
- N, 3, select width; output width is 2^N.
- DWELL, 1, cycles each code is held during a sweep (>=1).
- ACTIVE_LOW, 0, when 1 the decoded output is inverted (selected line 0, all others 1).

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; low freezes all state.
- in_valid  in  1  direct-mode request.
- in_sel  in  N  direct-mode select code.
- in_ready  out  1  high when a direct request can be accepted.
- sweep_start  in  1  request an autonomous sweep.
- out  out  2^N  registered decoded lines.
- out_valid  out  1  out currently carries a decoded code.
- cur_sel  out  N  code currently driven on out.
- sweep_done  out  1  one-cycle pulse at sweep completion.

Behaviour:
- Reset (rst=1 at a clk edge; has priority over everything, including mid-sweep):
  - state=IDLE, out_valid=0, cur_sel=0, sweep_done=0, dwell counter=0.
  - out = all 0 when ACTIVE_LOW=0; all 1 when ACTIVE_LOW=1.
  - in_ready is combinational: in_ready = (state==IDLE) & en & ~rst.
- FSM has two states, IDLE and SWEEP.
- IDLE:
  - A direct request is accepted when in_valid & in_ready & ~sweep_start.
    - Next edge: cur_sel=in_sel, out=onehot(in_sel), out_valid=1.
    - Latency 1 cycle. The value holds until the next accepted request or sweep.
  - sweep_start & en has priority over in_valid in the same cycle; that in_valid is not accepted.
    - Next edge: state=SWEEP, cur_sel=0, out=onehot(0), out_valid=1, dwell counter=0.
- SWEEP:
  - in_ready=0; in_valid and sweep_start are ignored.
  - Each enabled cycle increments the dwell counter. When it reaches DWELL-1:
    - counter returns to 0;
    - if cur_sel < 2^N-1, cur_sel increments and out follows it on the same edge;
    - if cur_sel = 2^N-1, the sweep ends (no wrap): state=IDLE, out=inactive pattern, out_valid=0, cur_sel=0, sweep_done=1 for exactly one cycle.
  - With DWELL=1, each code is held for exactly one cycle, so a full sweep asserts out_valid for 2^N consecutive cycles.
- en=0:
  - Every register holds, including the dwell counter and FSM state, so a sweep pauses.
  - No request is accepted.
  - sweep_done, if high, stays high until the next enabled edge clears it.
- out always has exactly one active line when out_valid=1, and none when out_valid=0.
- ACTIVE_LOW inverts only out; all other ports are unaffected.
- The dwell counter is max(1,$clog2(DWELL)) bits wide and never exceeds DWELL-1.

Decomposition:
- Shared package decoder_pkg holds:
  - state typedef {IDLE, SWEEP};
  - a onehot function (N-bit code to 2^N-bit one-hot).
- One natural sub-module, dwell_counter: an enable-gated modulo-DWELL counter with a terminal-count output. The top level holds the FSM, select register and output register.

Test Plan:
- Reset: rst=1 for 2 cycles with N=3, ACTIVE_LOW=0 -> out=8'h00, out_valid=0, cur_sel=0, sweep_done=0, in_ready=1 once rst falls.
- Direct decode: in_valid=1 with in_sel=5, then 3, then 6 on consecutive cycles -> one cycle later each: out=8'h20, 8'h08, 8'h40; out_valid stays 1.
- Sweep, DWELL=1: pulse sweep_start -> out steps 01,02,04,...,80 on 8 consecutive cycles with in_ready=0; then out=00, out_valid=0, and sweep_done=1 for exactly one cycle.
- Sweep, DWELL=3, with pause:
  - each code is held 3 cycles;
  - dropping en for 4 cycles while cur_sel=2 extends that code to 7 cycles;
  - sweep_done fires 24+4 cycles after start.
- Simultaneous events:
  - sweep_start and in_valid (in_sel=7) in the same cycle -> sweep begins with out=01, and the request is not accepted;
  - in_valid held high during the sweep is ignored and is accepted in the first cycle after sweep_done.
- Reset mid-sweep and ACTIVE_LOW=1:
  - rst asserted with cur_sel=4 -> next edge out=8'hFF, out_valid=0, state IDLE, and no sweep_done pulse;
  - a subsequent direct in_sel=0 gives out=8'hFE.
